// File: rtl/dct_result_serializer.sv
// ---------------------------------------------------------------------------
// dct_result_serializer
//   Takes one complete DCT result frame (N_POINTS coefficients on a flat bus)
//   per valid/ready handshake into a two-entry ping-pong buffer, then emits it
//   LANES coefficients per beat together with each coefficient's frequency
//   index, under downstream backpressure. Data passes through bit-exact.
//
//   Layout modes (sampled with the frame):
//     0 : natural order, slot k carries frequency k
//     1 : even/odd split, slots 0..N/2-1 carry even frequencies, the upper
//         half carries odd frequencies
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   in_valid      in   frame present on in_data_flat
//   in_ready      out  a frame buffer is free (registered state only)
//   in_mode       in   layout mode of the offered frame
//   in_data_flat  in   slot s at [s*DATA_W +: DATA_W]
//   out_valid     out  beat valid
//   out_ready     in   downstream accepts the beat
//   out_data      out  lane l at [l*DATA_W +: DATA_W]
//   out_idx       out  lane l frequency index at [l*IDX_W +: IDX_W]
//   out_last      out  final beat of the frame
//   frames_done   out  (DCT_SER_STATS_EN) saturating count of last beats
//   stall_cycles  out  (DCT_SER_STATS_EN) saturating count of stalled cycles
//
// Optional feature macro: DCT_SER_STATS_EN
// Parameter constraints: N_POINTS even and a multiple of LANES,
// 2**IDX_W >= N_POINTS.
// ---------------------------------------------------------------------------

// Per-lane slot select: maps (beat, lane, mode) to a buffer slot and index.
module dct_ser_lane #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 18,
  parameter int LANES    = 2,
  parameter int IDX_W    = 4,
  parameter int BEAT_W   = 3,
  parameter int LANE     = 0
) (
  input  logic                       valid_i,
  input  logic                       mode_i,
  input  logic [BEAT_W-1:0]          beat_i,
  input  logic [N_POINTS*DATA_W-1:0] frame_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [IDX_W-1:0]           idx_o
);
  int k;
  int slot;

  always_comb begin
    k = int'(beat_i) * LANES + LANE;
    if (!mode_i)       slot = k;
    else if (k[0] == 1'b0) slot = k / 2;
    else               slot = N_POINTS / 2 + k / 2;
    data_o = '0;
    idx_o  = '0;
    // Outputs are forced to zero whenever no beat is presented.
    if (valid_i) begin
      data_o = frame_i[slot*DATA_W +: DATA_W];
      idx_o  = IDX_W'(k);
    end
  end
endmodule

module dct_result_serializer #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 18,
  parameter int LANES    = 2,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [N_POINTS*DATA_W-1:0] in_data_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic [LANES*IDX_W-1:0]     out_idx,
`ifdef DCT_SER_STATS_EN
  output logic [15:0]                frames_done,
  output logic [15:0]                stall_cycles,
`endif
  output logic                       out_last
);
  localparam int BEATS  = N_POINTS / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [N_POINTS*DATA_W-1:0] buf_q [2];
  logic [1:0]                 mode_q;
  logic [1:0]                 fill_q, fill_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;

  logic accept, advance, retire;

  // Both handshake flags come straight from registered state.
  assign in_ready  = (fill_q < 2'd2);
  assign out_valid = (fill_q != 2'd0);
  assign out_last  = out_valid && (beat_q == LAST_BEAT);

  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready;
  assign retire  = advance && (beat_q == LAST_BEAT);

  always_comb begin
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ retire;
    beat_d   = beat_q;
    // Accept and retire on the same edge cancel; fill stays put.
    case ({accept, retire})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
    if (advance) beat_d = retire ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Frame storage carries no reset; fill_q gates whether it is ever read.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      buf_q[wr_ptr_q]  <= in_data_flat;
      mode_q[wr_ptr_q] <= in_mode;
    end
  end

  logic [N_POINTS*DATA_W-1:0] cur_frame;
  logic                       cur_mode;
  assign cur_frame = buf_q[rd_ptr_q];
  assign cur_mode  = mode_q[rd_ptr_q];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dct_ser_lane #(
      .N_POINTS(N_POINTS), .DATA_W(DATA_W), .LANES(LANES),
      .IDX_W(IDX_W), .BEAT_W(BEAT_W), .LANE(l)
    ) u_lane (
      .valid_i (out_valid),
      .mode_i  (cur_mode),
      .beat_i  (beat_q),
      .frame_i (cur_frame),
      .data_o  (out_data[l*DATA_W +: DATA_W]),
      .idx_o   (out_idx[l*IDX_W +: IDX_W])
    );
  end

`ifdef DCT_SER_STATS_EN
  logic [15:0] frames_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else begin
      if (retire && frames_q != 16'hFFFF)                     frames_q <= frames_q + 16'd1;
      if (out_valid && !out_ready && stall_q != 16'hFFFF)     stall_q  <= stall_q + 16'd1;
    end
  end

  assign frames_done  = frames_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: doc/dct_result_serializer.md
Name: dct_result_serializer

Overview:
Parametrised successor to the fixed 16-point, 2-lane DCT output serializer. It accepts one complete DCT result frame (N_POINTS coefficients, flat bus) per valid/ready handshake and stores it in a two-entry ping-pong frame buffer. It emits LANES coefficients per beat with their frequency indices, under downstream backpressure. It sits between the even/odd DCT cores and the design outputs, and supports both natural slot order and even/odd split layout.

Parameters:
N_POINTS, 16, coefficients per frame; must be a multiple of LANES and even.
DATA_W, 18, signed coefficient width.
LANES, 2, coefficients emitted per beat.
IDX_W, 4, index width; must satisfy 2**IDX_W >= N_POINTS.

Ports:
clk  in  1  clock, all logic on the rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  frame present on in_data_flat.
in_ready  out  1  a frame buffer is free.
in_mode  in  1  0 = natural order, 1 = even/odd split layout; sampled with the frame.
in_data_flat  in  N_POINTS*DATA_W  slot s occupies bits [s*DATA_W +: DATA_W].
out_valid  out  1  beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  LANES*DATA_W  lane l occupies bits [l*DATA_W +: DATA_W].
out_idx  out  LANES*IDX_W  frequency index per lane.
out_last  out  1  final beat of the frame.

Behaviour:
- Reset is synchronous, active-high, clock clk. It clears fill count, write pointer, read pointer and beat counter. out_valid, in_ready-state, out_last, out_data and out_idx all read 0 on the cycle after reset. in_ready = 1 after reset.
- A reset mid-frame drops all buffered frames. No partial beats are emitted afterwards.
- Frame accept: on the edge where in_valid && in_ready, store in_data_flat and in_mode into buffer[wr_ptr], toggle wr_ptr, fill++.
- in_ready = (fill < 2). It is derived from registered state only; there is no combinational path from out_ready or in_valid.
- Emission: out_valid = (fill > 0). It is not registered separately.
  - Frame accepted into an empty block at edge T gives out_valid = 1 in cycle T+1.
  - Beat b, lane l: frequency index k = b*LANES + l, for b = 0 .. BEATS-1 where BEATS = N_POINTS/LANES.
  - Mode 0: the beat outputs slot k.
  - Mode 1: the beat outputs slot k/2 if k is even, else slot N_POINTS/2 + k/2. Here slots 0..N/2-1 hold the even coefficients and the rest hold the odd ones.
  - out_idx lane l = k in both modes.
- out_last = out_valid && (beat == BEATS-1).
- While out_valid = 0: out_data and out_idx read 0.
- Beat advance happens on out_valid && out_ready. After the last beat: beat <= 0, rd_ptr toggles, fill--.
- Stall: while out_valid && !out_ready, out_data, out_idx and out_last stay stable.
- Simultaneous accept and final-beat retire in the same edge: fill is unchanged and both pointers toggle.
  - With fill = 2, in_ready = 0 on that edge, so no frame is accepted even though a buffer frees.
  - With fill = 1, back-to-back frames stream with zero bubble cycles.
- Throughput: 1 frame per BEATS cycles sustained with out_ready held high.
- No arithmetic is performed. Data passes through bit-exact and sign is preserved.

Optional Feature:
DCT_SER_STATS_EN. When defined, two extra output ports are added:
- frames_done (out, 16): increments on each out_last handshake.
- stall_cycles (out, 16): increments on each cycle with out_valid && !out_ready.
Both reset to 0 and saturate at 16'hFFFF. When undefined, neither the ports nor the counters exist, and the remaining behaviour is identical.

Test Plan:
- Defaults, mode 0, slot s = s+1, out_ready = 1, frame accepted at edge T.
  - Expect out_valid from T+1, 8 beats, beat b = {2b+2, 2b+1}, idx {2b+1, 2b}, out_last on beat 7 only.
- Mode 1 with slot s = 100+s.
  - Expect beat 0 = lanes {108, 100} idx {1, 0} and beat 3 = {111, 103} idx {7, 6}.
- Three frames offered back-to-back, out_ready = 0.
  - Expect 2 accepted, in_ready = 0 for the third, outputs frozen on beat 0.
  - Then release out_ready: expect all 24 beats in order with no gaps, and the third frame accepted on the cycle after frame 1's last beat.
- out_ready toggling 1,0,1,0 during a frame.
  - Expect each beat held stable while out_ready = 0, no beat duplicated or skipped, 16 cycles total.
- Reset asserted at beat 4 of a full buffer.
  - Expect out_valid = 0, in_ready = 1 the next cycle; a new frame then starts at beat 0.
- With DCT_SER_STATS_EN defined, run 2 frames with 5 stall cycles.
  - Expect frames_done = 2 and stall_cycles = 5.
